// File: rtl/raid_stripe_sched_if.sv
// raid_stripe_sched_if: request, SD-card and block-buffer signals of the RAID5 stripe sequencer.
// slave = sequencer side, master = control-unit / datapath side.
interface raid_stripe_sched_if #(
  parameter int unsigned AW = 7
);
  // request / completion
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [31:0]   req_lba;
  logic          busy;
  logic          done;
  logic          err;
  logic          rd_src_par;
  // SD card command / transfer
  logic          sd_start;
  logic          sd_mode;
  logic [1:0]    sd_sel;
  logic [31:0]   sd_block_no;
  logic          sd_ready;
  logic          sd_word_valid;
  logic [1:0]    sd_error;
  // block buffer addressing and parity XOR control
  logic [1:0]    buf_sel;
  logic [AW-1:0] buf_addr;
  logic          buf_we;
  logic          xor_en;

  modport slave (
    input  req_valid, req_write, req_lba, sd_ready, sd_word_valid, sd_error,
    output req_ready, busy, done, err, rd_src_par,
           sd_start, sd_mode, sd_sel, sd_block_no,
           buf_sel, buf_addr, buf_we, xor_en
  );

  modport master (
    output req_valid, req_write, req_lba, sd_ready, sd_word_valid, sd_error,
    input  req_ready, busy, done, err, rd_src_par,
           sd_start, sd_mode, sd_sel, sd_block_no,
           buf_sel, buf_addr, buf_we, xor_en
  );
endinterface

// File: rtl/raid_stripe_sched.sv
// raid_stripe_sched: RAID5 block sequencer over three SD cards (2 data + rotating parity).
// Maps a logical block to stripe/data/parity cards, runs the SD command/transfer phases,
// steers block-buffer addressing and parity XOR, and reports completion.
// Optional feature macro: DEGRADED_READ_EN (read reconstruction from the surviving cards).
module raid_stripe_sched #(
  parameter int unsigned WORDS_PER_BLOCK = 128,
  parameter int unsigned MAX_RETRY       = 2
) (
  input  logic               clk,
  input  logic               rst,
  raid_stripe_sched_if.slave bus
);

  localparam int unsigned AW = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);
  localparam logic [AW-1:0] LAST_WORD = AW'(WORDS_PER_BLOCK - 1);
  localparam logic [1:0] BUF_NEW = 2'd0;
  localparam logic [1:0] BUF_PAR = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_MAP, S_CMD, S_XFER, S_NEXT, S_DONE} state_t;
  typedef enum logic [2:0] {PH_R1, PH_R2, PH_R3, PH_W1, PH_W2, PH_W3, PH_W4} phase_t;

  state_t          r_state;
  phase_t          r_phase;
  logic [31:0]     r_lba;
  logic [1:0]      r_card_p;
  logic [1:0]      r_card_d;
  logic [1:0]      r_card_o;
  logic [RW-1:0]   r_retry;
  logic [AW-1:0]   r_buf_addr;
  logic            r_req_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic            r_sd_start;
  logic            r_sd_mode;
  logic [1:0]      r_sd_sel;
  logic [31:0]     r_sd_block_no;
  logic [1:0]      r_buf_sel;
  logic            r_xor_en;
`ifdef DEGRADED_READ_EN
  logic            r_rd_src_par;
`endif

  logic [31:0]     w_stripe;
  logic [1:0]      w_card_p;
  logic [1:0]      w_card_lo;
  logic [1:0]      w_card_hi;
  logic            w_sd_err;
  logic            w_exhausted;
  logic            w_abort;
  logic            w_last;
  logic            w_final;
  logic            w_fallback;
  phase_t          w_phase_succ;

  assign w_stripe    = r_lba >> 1;
  assign w_card_p    = 2'(w_stripe % 32'd3);
  assign w_sd_err    = |bus.sd_error;
  assign w_exhausted = (r_retry == RW'(MAX_RETRY));
  assign w_last      = (r_buf_addr == LAST_WORD);
  assign w_final     = (r_phase inside {PH_R1, PH_R3, PH_W4});
  // A fault while waiting for a busy card or during the transfer aborts the phase.
  assign w_abort     = w_sd_err &&
                       (((r_state == S_CMD) && !bus.sd_ready) || (r_state == S_XFER));

`ifdef DEGRADED_READ_EN
  assign w_fallback  = (r_phase == PH_R1);
`else
  assign w_fallback  = 1'b0;
`endif

  // Data cards are the two non-parity cards in ascending order.
  always_comb begin
    w_card_lo = 2'd0;
    w_card_hi = 2'd1;
    case (w_card_p)
      2'd0:    begin w_card_lo = 2'd1; w_card_hi = 2'd2; end
      2'd1:    begin w_card_lo = 2'd0; w_card_hi = 2'd2; end
      default: ;
    endcase
  end

  // Phase that follows a successfully completed non-final phase.
  always_comb begin
    w_phase_succ = PH_W4;
    case (r_phase)
      PH_R2:   w_phase_succ = PH_R3;
      PH_W1:   w_phase_succ = PH_W2;
      PH_W2:   w_phase_succ = PH_W3;
      default: w_phase_succ = PH_W4;
    endcase
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_phase       <= PH_R1;
      r_lba         <= '0;
      r_card_p      <= '0;
      r_card_d      <= '0;
      r_card_o      <= '0;
      r_retry       <= '0;
      r_buf_addr    <= '0;
      r_req_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_sd_start    <= 1'b0;
      r_sd_mode     <= 1'b0;
      r_sd_sel      <= '0;
      r_sd_block_no <= '0;
      r_buf_sel     <= '0;
      r_xor_en      <= 1'b0;
`ifdef DEGRADED_READ_EN
      r_rd_src_par  <= 1'b0;
`endif
    end else begin
      r_sd_start <= 1'b0;
      if (w_abort) begin
        r_buf_addr <= '0;
        if (!w_exhausted) begin
          r_retry <= r_retry + RW'(1);
          r_state <= S_CMD;
        end else if (w_fallback) begin
          r_phase  <= PH_R2;
          r_xor_en <= 1'b0;
          r_state  <= S_NEXT;
        end else begin
          r_xor_en <= 1'b0;
          r_done   <= 1'b1;
          r_err    <= 1'b1;
          r_state  <= S_DONE;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.req_valid && r_req_ready) begin
              r_lba       <= bus.req_lba;
              r_phase     <= bus.req_write ? PH_W1 : PH_R1;
              r_req_ready <= 1'b0;
              r_busy      <= 1'b1;
              r_state     <= S_MAP;
            end
          end
          S_MAP: begin
            r_sd_block_no <= w_stripe;
            r_card_p      <= w_card_p;
            r_card_d      <= r_lba[0] ? w_card_hi : w_card_lo;
            r_card_o      <= r_lba[0] ? w_card_lo : w_card_hi;
            r_state       <= S_NEXT;
          end
          S_NEXT: begin
            r_retry    <= '0;
            r_buf_addr <= '0;
            r_state    <= S_CMD;
            case (r_phase)
              PH_R1:   begin r_sd_sel <= r_card_d; r_sd_mode <= 1'b1; r_buf_sel <= BUF_NEW; r_xor_en <= 1'b0; end
              PH_R2:   begin r_sd_sel <= r_card_o; r_sd_mode <= 1'b1; r_buf_sel <= BUF_PAR; r_xor_en <= 1'b0; end
              PH_R3:   begin r_sd_sel <= r_card_p; r_sd_mode <= 1'b1; r_buf_sel <= BUF_PAR; r_xor_en <= 1'b1; end
              PH_W1:   begin r_sd_sel <= r_card_d; r_sd_mode <= 1'b1; r_buf_sel <= BUF_PAR; r_xor_en <= 1'b0; end
              PH_W2:   begin r_sd_sel <= r_card_p; r_sd_mode <= 1'b1; r_buf_sel <= BUF_PAR; r_xor_en <= 1'b1; end
              PH_W3:   begin r_sd_sel <= r_card_d; r_sd_mode <= 1'b0; r_buf_sel <= BUF_NEW; r_xor_en <= 1'b1; end
              default: begin r_sd_sel <= r_card_p; r_sd_mode <= 1'b0; r_buf_sel <= BUF_PAR; r_xor_en <= 1'b0; end
            endcase
          end
          S_CMD: begin
            if (bus.sd_ready) begin
              r_sd_start <= 1'b1;
              r_state    <= S_XFER;
            end
          end
          S_XFER: begin
            if (bus.sd_word_valid) begin
              if (w_last) begin
                r_buf_addr <= '0;
                if (w_final) begin
                  r_xor_en <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
`ifdef DEGRADED_READ_EN
                  r_rd_src_par <= (r_phase == PH_R3);
`endif
                end else begin
                  r_phase <= w_phase_succ;
                  r_state <= S_NEXT;
                end
              end else begin
                r_buf_addr <= r_buf_addr + AW'(1);
              end
            end
          end
          S_DONE: begin
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
`ifdef DEGRADED_READ_EN
            r_rd_src_par <= 1'b0;
`endif
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Buffer write strobe tracks the live SD word so it lines up with the current buf_addr.
  assign bus.buf_we      = (r_state == S_XFER) && bus.sd_word_valid && !w_sd_err && r_sd_mode;

  assign bus.req_ready   = r_req_ready;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
  assign bus.sd_start    = r_sd_start;
  assign bus.sd_mode     = r_sd_mode;
  assign bus.sd_sel      = r_sd_sel;
  assign bus.sd_block_no = r_sd_block_no;
  assign bus.buf_sel     = r_buf_sel;
  assign bus.buf_addr    = r_buf_addr;
  assign bus.xor_en      = r_xor_en;
`ifdef DEGRADED_READ_EN
  assign bus.rd_src_par  = r_rd_src_par;
`else
  assign bus.rd_src_par  = 1'b0;
`endif

endmodule

// File: tb/tb_raid_stripe_sched.sv
// tb_raid_stripe_sched: directed bench for the RAID5 stripe sequencer.
module tb_raid_stripe_sched;

  localparam logic [1:0] BUF_NEW = 2'd0;
  localparam logic [1:0] BUF_PAR = 2'd2;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  raid_stripe_sched_if bus ();

  raid_stripe_sched #(.WORDS_PER_BLOCK(128), .MAX_RETRY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request at a negedge while the sequencer is idle.
  task automatic issue(input string name, input logic wr, input logic [31:0] lba);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_lba   = lba;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check($sformatf("%s_busy", name), 32'(bus.busy), 32'd1);
    check($sformatf("%s_req_ready", name), 32'(bus.req_ready), 32'd0);
  endtask

  // Act as the selected SD card for one phase; optionally inject an error or a reset.
  task automatic serve_phase(input string name, input logic [1:0] sel, input logic mode,
                             input logic [1:0] bsel, input logic xe, input logic [31:0] blk,
                             input int err_at, input int rst_at);
    int wait_cyc  = 0;
    int we_cnt    = 0;
    int addr_bad  = 0;
    int start_bad = 0;
    while (bus.sd_start !== 1'b1 && wait_cyc < 40) begin
      @(negedge clk);
      wait_cyc++;
    end
    check($sformatf("%s_start_seen", name), 32'(bus.sd_start), 32'd1);
    if (bus.sd_start !== 1'b1) return;
    check($sformatf("%s_sel", name), 32'(bus.sd_sel), 32'(sel));
    check($sformatf("%s_mode", name), 32'(bus.sd_mode), 32'(mode));
    check($sformatf("%s_buf_sel", name), 32'(bus.buf_sel), 32'(bsel));
    check($sformatf("%s_xor_en", name), 32'(bus.xor_en), 32'(xe));
    check($sformatf("%s_block_no", name), bus.sd_block_no, blk);
    for (int w = 0; w < 128; w++) begin
      if (bus.buf_addr !== 7'(w)) addr_bad++;
      if (w > 0 && bus.sd_start !== 1'b0) start_bad++;
      if (w == rst_at) begin
        bus.sd_word_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check($sformatf("%s_addr_before_rst", name), 32'(addr_bad), 32'd0);
        return;
      end
      bus.sd_word_valid = 1'b1;
      if (w == err_at) begin
        bus.sd_error = 2'b01;
        #1;
        check($sformatf("%s_we_on_err", name), 32'(bus.buf_we), 32'd0);
        @(negedge clk);
        bus.sd_word_valid = 1'b0;
        bus.sd_error      = 2'b00;
        check($sformatf("%s_addr_after_err", name), 32'(bus.buf_addr), 32'd0);
        check($sformatf("%s_addr_before_err", name), 32'(addr_bad), 32'd0);
        return;
      end
      #1;
      if (bus.buf_we === 1'b1) we_cnt++;
      @(negedge clk);
    end
    bus.sd_word_valid = 1'b0;
    check($sformatf("%s_we_count", name), 32'(we_cnt), mode ? 32'd128 : 32'd0);
    check($sformatf("%s_addr_seq", name), 32'(addr_bad), 32'd0);
    check($sformatf("%s_start_pulse", name), 32'(start_bad), 32'd0);
    check($sformatf("%s_addr_wrap", name), 32'(bus.buf_addr), 32'd0);
  endtask

  // Completion pulse now, idle and ready one cycle later.
  task automatic expect_done(input string name, input logic e_err, input logic e_par);
    check($sformatf("%s_done", name), 32'(bus.done), 32'd1);
    check($sformatf("%s_err", name), 32'(bus.err), 32'(e_err));
    check($sformatf("%s_rd_src_par", name), 32'(bus.rd_src_par), 32'(e_par));
    check($sformatf("%s_busy_at_done", name), 32'(bus.busy), 32'd1);
    @(negedge clk);
    check($sformatf("%s_done_low", name), 32'(bus.done), 32'd0);
    check($sformatf("%s_ready_back", name), 32'(bus.req_ready), 32'd1);
    check($sformatf("%s_busy_low", name), 32'(bus.busy), 32'd0);
  endtask

  task automatic check_reset_state(input string name);
    check($sformatf("%s_req_ready", name), 32'(bus.req_ready), 32'd1);
    check($sformatf("%s_busy", name), 32'(bus.busy), 32'd0);
    check($sformatf("%s_done", name), 32'(bus.done), 32'd0);
    check($sformatf("%s_err", name), 32'(bus.err), 32'd0);
    check($sformatf("%s_sd_start", name), 32'(bus.sd_start), 32'd0);
    check($sformatf("%s_sd_mode", name), 32'(bus.sd_mode), 32'd0);
    check($sformatf("%s_sd_sel", name), 32'(bus.sd_sel), 32'd0);
    check($sformatf("%s_block_no", name), bus.sd_block_no, 32'd0);
    check($sformatf("%s_buf_sel", name), 32'(bus.buf_sel), 32'd0);
    check($sformatf("%s_buf_addr", name), 32'(bus.buf_addr), 32'd0);
    check($sformatf("%s_buf_we", name), 32'(bus.buf_we), 32'd0);
    check($sformatf("%s_xor_en", name), 32'(bus.xor_en), 32'd0);
    check($sformatf("%s_rd_src_par", name), 32'(bus.rd_src_par), 32'd0);
  endtask

  initial begin
    int starts;
    int cyc;
    int done_seen;

    rst               = 1'b1;
    bus.req_valid     = 1'b0;
    bus.req_write     = 1'b0;
    bus.req_lba       = '0;
    bus.sd_ready      = 1'b1;
    bus.sd_word_valid = 1'b0;
    bus.sd_error      = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state("RST");
    @(negedge clk);

    // T1: read lba 5 -> stripe 2, parity card 2, data card 1
    issue("T1", 1'b0, 32'd5);
    serve_phase("T1_R1", 2'd1, 1'b1, BUF_NEW, 1'b0, 32'd2, -1, -1);
    expect_done("T1", 1'b0, 1'b0);

    // T2: write lba 6 -> stripe 3, parity card 0, data card 1
    issue("T2", 1'b1, 32'd6);
    serve_phase("T2_W1", 2'd1, 1'b1, BUF_PAR, 1'b0, 32'd3, -1, -1);
    serve_phase("T2_W2", 2'd0, 1'b1, BUF_PAR, 1'b1, 32'd3, -1, -1);
    serve_phase("T2_W3", 2'd1, 1'b0, BUF_NEW, 1'b1, 32'd3, -1, -1);
    serve_phase("T2_W4", 2'd0, 1'b0, BUF_PAR, 1'b0, 32'd3, -1, -1);
    expect_done("T2", 1'b0, 1'b0);

    // T3: write lba 1 -> stripe 0, parity card 0, data card 2; first W2 attempt faults
    issue("T3", 1'b1, 32'd1);
    serve_phase("T3_W1", 2'd2, 1'b1, BUF_PAR, 1'b0, 32'd0, -1, -1);
    serve_phase("T3_W2a", 2'd0, 1'b1, BUF_PAR, 1'b1, 32'd0, 10, -1);
    serve_phase("T3_W2b", 2'd0, 1'b1, BUF_PAR, 1'b1, 32'd0, -1, -1);
    serve_phase("T3_W3", 2'd2, 1'b0, BUF_NEW, 1'b1, 32'd0, -1, -1);
    serve_phase("T3_W4", 2'd0, 1'b0, BUF_PAR, 1'b0, 32'd0, -1, -1);
    expect_done("T3", 1'b0, 1'b0);

    // T4: read lba 0 -> data card 1 (stuck faulty), other data card 2, parity card 0
    issue("T4", 1'b0, 32'd0);
    starts = 0;
    cyc    = 0;
    while (cyc < 60) begin
      bus.sd_error = (bus.sd_sel == 2'd1) ? 2'b01 : 2'b00;
      if (bus.sd_start === 1'b1 && bus.sd_sel == 2'd1) starts++;
`ifdef DEGRADED_READ_EN
      if (starts > 0 && bus.sd_sel != 2'd1) break;
`else
      if (bus.done === 1'b1) break;
`endif
      @(negedge clk);
      cyc++;
    end
    bus.sd_error = 2'b00;
    check("T4_card1_starts", 32'(starts), 32'd3);
`ifdef DEGRADED_READ_EN
    serve_phase("T4_R2", 2'd2, 1'b1, BUF_PAR, 1'b0, 32'd0, -1, -1);
    serve_phase("T4_R3", 2'd0, 1'b1, BUF_PAR, 1'b1, 32'd0, -1, -1);
    expect_done("T4", 1'b0, 1'b1);
`else
    expect_done("T4", 1'b1, 1'b0);
`endif

    // T5: reset at word 60 of W3, then a clean read
    issue("T5", 1'b1, 32'd6);
    serve_phase("T5_W1", 2'd1, 1'b1, BUF_PAR, 1'b0, 32'd3, -1, -1);
    serve_phase("T5_W2", 2'd0, 1'b1, BUF_PAR, 1'b1, 32'd3, -1, -1);
    serve_phase("T5_W3", 2'd1, 1'b0, BUF_NEW, 1'b1, 32'd3, -1, 60);
    check_reset_state("T5_RST");
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.sd_start === 1'b1) done_seen++;
    end
    check("T5_quiet_after_rst", 32'(done_seen), 32'd0);
    issue("T5b", 1'b0, 32'd5);
    serve_phase("T5b_R1", 2'd1, 1'b1, BUF_NEW, 1'b0, 32'd2, -1, -1);
    expect_done("T5b", 1'b0, 1'b0);

    // T6: req_valid held across a busy read (lba 10 -> stripe 5, data card 0)
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_lba   = 32'd10;
    @(negedge clk);
    check("T6_busy", 32'(bus.busy), 32'd1);
    check("T6_ready_low", 32'(bus.req_ready), 32'd0);
    serve_phase("T6_R1", 2'd0, 1'b1, BUF_NEW, 1'b0, 32'd5, -1, -1);
    check("T6_done", 32'(bus.done), 32'd1);
    check("T6_ready_at_done", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("T6_ready_after_done", 32'(bus.req_ready), 32'd1);
    check("T6_idle_after_done", 32'(bus.busy), 32'd0);
    // second request: lba 3 -> stripe 1, parity card 1, data card 2
    bus.req_lba = 32'd3;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("T6_second_accept", 32'(bus.busy), 32'd1);
    check("T6_second_ready_low", 32'(bus.req_ready), 32'd0);
    serve_phase("T6_R1b", 2'd2, 1'b1, BUF_NEW, 1'b0, 32'd1, -1, -1);
    expect_done("T6b", 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound so a stalled handshake still ends the run.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion (%0d/%0d)", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
